// File: rtl/alu_exec_unit.sv
// EX-stage ALU: ALUOp/funct decode, single-cycle add/sub/and/or, iterative shift-add mul,
// valid/ready on both sides. Define ALU_SLT_EN to add signed set-less-than (funct 0x2A).
module alu_exec_unit #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic [2:0]        ALUCtrl_o,
  output logic              illegal_o
);

  localparam int N     = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [2:0]          dec_ctrl;
  logic                dec_illegal, dec_is_mul, accept;
  logic [DATA_W-1:0]   exec_res, partial, acc_sum;

  assign ready_o = (state_q == IDLE) && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    dec_ctrl    = 3'b000;
    dec_illegal = 1'b0;
    unique case (ALUOp_i)
      2'b00: dec_ctrl = 3'b010;
      2'b01: dec_ctrl = 3'b110;
      2'b10: dec_ctrl = 3'b001;
      default: begin
        unique case (funct_i)
          6'h20: dec_ctrl = 3'b010;
          6'h22: dec_ctrl = 3'b110;
          6'h24: dec_ctrl = 3'b000;
          6'h25: dec_ctrl = 3'b001;
          6'h18: dec_ctrl = 3'b101;
`ifdef ALU_SLT_EN
          6'h2A: dec_ctrl = 3'b111;
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign dec_is_mul = !dec_illegal && (dec_ctrl == 3'b101);

  always_comb begin
    exec_res = '0;
    if (!dec_illegal) begin
      unique case (dec_ctrl)
        3'b010: exec_res = src1_i + src2_i;
        3'b110: exec_res = src1_i - src2_i;
        3'b000: exec_res = src1_i & src2_i;
        3'b001: exec_res = src1_i | src2_i;
`ifdef ALU_SLT_EN
        3'b111: exec_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
`endif
        default: exec_res = '0;
      endcase
    end
  end

  // a_q is pre-shifted each step, so bit j of b_q weights a_q << j.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (b_q[j]) partial = partial + (a_q << j);
    end
    acc_sum = acc_q + partial;
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_is_mul) begin
            a_d     = src1_i;
            b_d     = src2_i;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = MUL_RUN;
          end else begin
            result_d  = exec_res;
            zero_d    = (exec_res == '0);
            ctrl_d    = dec_ctrl;
            illegal_d = dec_illegal;
            valid_d   = 1'b1;
          end
        end else if (ready_i) begin
          valid_d = 1'b0;
        end
      end
      MUL_RUN: begin
        acc_d = acc_sum;
        a_d   = a_q << MUL_STEP;
        b_d   = b_q >> MUL_STEP;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          result_d  = acc_sum;
          zero_d    = (acc_sum == '0);
          ctrl_d    = 3'b101;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ctrl_q    <= 3'b000;
      illegal_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign ALUCtrl_o = ctrl_q;
  assign illegal_o = illegal_q;

endmodule
